alu_sequencer: RTL and testbench

Sequencer that owns a 4-entry × 4-bit register file and drives the combinational `Decode_And_Execute` ALU (4-bit `rs`/`rt`, 3-bit `sel`, 4-bit `rd`).
- Accepts one instruction at a time over a valid/ready input, reads operands, executes, then presents the result on a valid/ready output.
- Writes the result back to the register file on output handshake.
- Sits between the lab's instruction source (switches/testbench driver) and the display/result sink.

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu_sequencer_if.sv | 27 ++
 rtl/Decode_And_Execute.sv | 26 ++
 rtl/alu_sequencer.sv | 116 +++++++++++
 tb/tb_alu_sequencer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: opcodes, FSM states,
// instruction field positions and compare-result bases.
package alu_seq_pkg;

    localparam int RF_DEPTH = 4;
    localparam int DATA_W   = 4;
    localparam int IDX_W    = 2;
    localparam int INSTR_W  = 9;

    localparam int OP_MSB = 8;
    localparam int OP_LSB = 6;
    localparam int RD_MSB = 5;
    localparam int RD_LSB = 4;
    localparam int RS_MSB = 3;
    localparam int RS_LSB = 2;
    localparam int RT_MSB = 1;
    localparam int RT_LSB = 0;

    localparam logic [DATA_W-1:0] LT_BASE = 4'b1010;
    localparam logic [DATA_W-1:0] EQ_BASE = 4'b1110;

    typedef enum logic [2:0] {
        OP_SUB = 3'd0,
        OP_ADD = 3'd1,
        OP_OR  = 3'd2,
        OP_AND = 3'd3,
        OP_ROR = 3'd4,
        OP_ROL = 3'd5,
        OP_LT  = 3'd6,
        OP_EQ  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction, config-write and result handshake bundle for alu_sequencer.
// master = instruction source / result sink side, slave = the sequencer.
interface alu_sequencer_if;
    import alu_seq_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_idx;
    logic [DATA_W-1:0]  cfg_data;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [IDX_W-1:0]   out_rd;

    modport master (
        output in_valid, in_instr, cfg_we, cfg_idx, cfg_data, out_ready,
        input  in_ready, out_valid, out_data, out_rd
    );

    modport slave (
        input  in_valid, in_instr, cfg_we, cfg_idx, cfg_data, out_ready,
        output in_ready, out_valid, out_data, out_rd
    );

endinterface

// File: rtl/Decode_And_Execute.sv
// Combinational 4-bit ALU: decodes the 3-bit select and produces the result.
module Decode_And_Execute
    import alu_seq_pkg::*;
(
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    input  logic [2:0]        sel,
    output logic [DATA_W-1:0] rd
);

    always_comb begin
        rd = '0;
        case (op_t'(sel))
            OP_SUB: rd = rs - rt;
            OP_ADD: rd = rs + rt;
            OP_OR:  rd = rs | rt;
            OP_AND: rd = rs & rt;
            OP_ROR: rd = {rt[0], rt[3:1]};
            OP_ROL: rd = {rs[2:0], rs[3]};
            OP_LT:  rd = LT_BASE + {3'b000, (rs < rt)};
            OP_EQ:  rd = EQ_BASE + {3'b000, (rs == rt)};
            default: rd = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Four-state sequencer around Decode_And_Execute with an inline 4x4 register
// file. Define ALU_SEQ_STATS_EN to add the 8-bit retired-instruction counter.
//
// state | meaning
// IDLE  | in_ready high, waiting for an instruction
// READ  | capture both operands from the register file
// EXEC  | capture the ALU result
// WB    | present result; write back on output handshake
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NREG = 4,
    parameter int DW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ALU_SEQ_STATS_EN
    output logic [7:0]       retired,
`endif
    alu_sequencer_if.slave   bus
);

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   rf [NREG];
    op_t             op_q;
    logic [IDX_W-1:0] rd_q;
    logic [IDX_W-1:0] rs_idx;
    logic [IDX_W-1:0] rt_idx;
    logic [DW-1:0]   rs_q;
    logic [DW-1:0]   rt_q;
    logic [DW-1:0]   res_q;
    logic [DW-1:0]   alu_res;
    logic            accept;
    logic            wb_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)  state_nxt = READ;
            READ:              state_nxt = EXEC;
            EXEC:              state_nxt = WB;
            WB:   if (wb_fire) state_nxt = IDLE;
            default:           state_nxt = IDLE;
        endcase
    end

    // in_ready is gated by rst_n so it reads 0 for the whole reset window.
    always_comb begin
        bus.in_ready  = rst_n && (state == IDLE);
        bus.out_valid = (state == WB);
        bus.out_data  = res_q;
        bus.out_rd    = rd_q;
        accept        = bus.in_valid && bus.in_ready;
        wb_fire       = bus.out_valid && bus.out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_SUB;
            rd_q   <= '0;
            rs_idx <= '0;
            rt_idx <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            res_q  <= '0;
        end else begin
            if (accept) begin
                op_q   <= op_t'(bus.in_instr[OP_MSB:OP_LSB]);
                rd_q   <= bus.in_instr[RD_MSB:RD_LSB];
                rs_idx <= bus.in_instr[RS_MSB:RS_LSB];
                rt_idx <= bus.in_instr[RT_MSB:RT_LSB];
            end
            if (state == READ) begin
                rs_q <= rf[rs_idx];
                rt_q <= rf[rt_idx];
            end
            if (state == EXEC) res_q <= alu_res;
        end
    end

    // Write-back takes priority over a config write to the same entry;
    // writes to different entries in the same cycle both land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wb_fire && (rd_q == IDX_W'(i)))
                    rf[i] <= res_q;
                else if (bus.cfg_we && (bus.cfg_idx == IDX_W'(i)))
                    rf[i] <= bus.cfg_data;
            end
        end
    end

    Decode_And_Execute u_alu (
        .rs  (rs_q),
        .rt  (rt_q),
        .sel (op_q),
        .rd  (alu_res)
    );

`ifdef ALU_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       retired <= '0;
        else if (wb_fire) retired <= retired + 8'd1;
    end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer against an arithmetic
// reference model of the register file and ALU.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_sequencer_if bus ();
`ifdef ALU_SEQ_STATS_EN
    logic [7:0] retired;
`endif

    alu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef ALU_SEQ_STATS_EN
        .retired (retired),
`endif
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_ret = 0;
    int rf_m [4];

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_alu(input int op, input int a, input int b);
        case (op)
            0: return (a - b + 16) % 16;
            1: return (a + b) % 16;
            2: return a | b;
            3: return a & b;
            4: return (b / 2) + (b % 2) * 8;
            5: return ((a * 2) % 16) + (a / 8);
            6: return 10 + ((a < b) ? 1 : 0);
            default: return 14 + ((a == b) ? 1 : 0);
        endcase
    endfunction

    task automatic cfg_write(input int idx, input int data);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_idx  = 2'(idx);
        bus.cfg_data = 4'(data);
        @(negedge clk);
        bus.cfg_we = 1'b0;
        rf_m[idx] = data;
    endtask

    // mode 0: plain; 1: cfg write to rs during READ (old value used);
    // 2: cfg write to rd in the write-back handshake cycle (write-back wins).
    task automatic issue(input int op, input int rd, input int rs, input int rt,
                         input int hold, input int mode, input int cdata);
        int exp;
        @(negedge clk);
        check("in_ready_idle", int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_instr = {3'(op), 2'(rd), 2'(rs), 2'(rt)};
        exp = ref_alu(op, rf_m[rs], rf_m[rt]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("read_out_valid", int'(bus.out_valid), 0);
        check("read_in_ready", int'(bus.in_ready), 0);
        if (mode == 1) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_idx  = 2'(rs);
            bus.cfg_data = 4'(cdata);
        end
        @(negedge clk);
        bus.cfg_we = 1'b0;
        if (mode == 1) rf_m[rs] = cdata;
        check("exec_out_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        check("wb_out_valid", int'(bus.out_valid), 1);
        check("wb_out_data", int'(bus.out_data), exp);
        check("wb_out_rd", int'(bus.out_rd), rd);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_out_valid", int'(bus.out_valid), 1);
            check("hold_out_data", int'(bus.out_data), exp);
            check("hold_in_ready", int'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        if (mode == 2) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_idx  = 2'(rd);
            bus.cfg_data = 4'(cdata);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.cfg_we    = 1'b0;
        rf_m[rd] = exp;
        n_ret++;
        check("post_out_valid", int'(bus.out_valid), 0);
        check("post_in_ready", int'(bus.in_ready), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_idx   = '0;
        bus.cfg_data  = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) rf_m[i] = 0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_out_rd", int'(bus.out_rd), 0);
`ifdef ALU_SEQ_STATS_EN
        check("rst_retired", int'(retired), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", int'(bus.in_ready), 1);

        // Directed: basic ops with R1=7, R2=3
        cfg_write(1, 7);
        cfg_write(2, 3);
        issue(1, 0, 1, 2, 0, 0, 0);
        check("add_r0", rf_m[0], 10);
        issue(0, 3, 2, 1, 0, 0, 0);
        check("sub_wrap", rf_m[3], 12);
        issue(4, 3, 0, 1, 0, 0, 0);
        check("ror", rf_m[3], 11);
        issue(5, 3, 1, 0, 0, 0, 0);
        check("rol", rf_m[3], 14);
        issue(6, 3, 2, 1, 0, 0, 0);
        check("lt", rf_m[3], 11);
        issue(7, 3, 1, 1, 0, 0, 0);
        check("eq", rf_m[3], 15);
        // Dependency chain, then backpressure, read-old, collision
        issue(1, 3, 1, 2, 0, 0, 0);
        issue(2, 0, 3, 2, 5, 0, 0);
        check("dep_or", rf_m[0], 11);
        issue(2, 3, 0, 0, 0, 0, 0);
        issue(1, 1, 1, 2, 0, 1, 9);
        issue(2, 3, 1, 1, 0, 0, 0);
        issue(1, 0, 1, 2, 0, 2, 5);
        issue(2, 3, 0, 0, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0)
                cfg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 15)));
        end
`ifdef ALU_SEQ_STATS_EN
        check("retired_count", int'(retired), n_ret % 256);
`endif

        // Reset during EXEC discards the in-flight instruction
        cfg_write(1, 7);
        cfg_write(2, 3);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = {3'(1), 2'(0), 2'(1), 2'(2)};
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(bus.out_valid), 0);
        check("mid_rst_in_ready", int'(bus.in_ready), 0);
        check("mid_rst_out_data", int'(bus.out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) rf_m[i] = 0;
        n_ret = 0;
        @(negedge clk);
        check("mid_rst_out_valid2", int'(bus.out_valid), 0);
`ifdef ALU_SEQ_STATS_EN
        check("mid_rst_retired", int'(retired), 0);
`endif
        for (int k = 0; k < 4; k++) issue(2, k, k, k, 0, 0, 0);

`ifdef ALU_SEQ_STATS_EN
        while (n_ret < 257)
            issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  0, 0, 0);
        check("retired_wrap", int'(retired), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
